// File: rtl/tsetlin_pkg.sv
// rtl/tsetlin_pkg.sv - shared LFSR geometry, default seed and feedback encoding for the Tsetlin environment
package tsetlin_pkg;

    localparam int LFSR_W = 8;

    // Feedback taps at bits 7,5,4,3 realise x^8+x^6+x^5+x^4+1 (maximal length, period 255)
    localparam logic [LFSR_W-1:0] LFSR_TAPS         = 8'b1011_1000;
    localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 8'hA5;

    localparam logic PENALTY = 1'b1;
    localparam logic REWARD  = 1'b0;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

    // An all-zero state would lock the LFSR, so a zero seed is promoted to one
    function automatic logic [LFSR_W-1:0] lfsr_safe_seed(input logic [LFSR_W-1:0] s);
        return (s == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : s;
    endfunction

endpackage

// File: rtl/tsetlin_lfsr.sv
// rtl/tsetlin_lfsr.sv - 8-bit Fibonacci LFSR, advances once per enabled edge
module tsetlin_lfsr
    import tsetlin_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [LFSR_W-1:0] q
);

    localparam logic [LFSR_W-1:0] RESET_STATE = lfsr_safe_seed(SEED);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= RESET_STATE;
        end else if (en) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/tsetlin_env.sv
// rtl/tsetlin_env.sv - stochastic reward/penalty environment with convergence detector
// Optional step/penalty statistics counters enabled by defining TSETLIN_ENV_STATS_EN.
module tsetlin_env
    import tsetlin_pkg::*;
#(
    parameter logic [7:0] LFSR_SEED = LFSR_DEFAULT_SEED,
    parameter logic [7:0] C0        = 8'd51,
    parameter logic [7:0] C1        = 8'd204,
    parameter int         CONV_LEN  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        alpha,
    output logic        x,
    output logic        converged,
    output logic        conv_action
`ifdef TSETLIN_ENV_STATS_EN
    ,
    output logic [15:0] step_cnt,
    output logic [15:0] pen_cnt
`endif
);

    localparam logic [7:0] CONV_MAX = 8'(CONV_LEN);

    logic [7:0] lfsr_q;
    logic [7:0] run_cnt;
    logic [7:0] run_next;
    logic       x_next;

    tsetlin_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .q   (lfsr_q)
    );

    // Compare uses the pre-advance LFSR value; the LFSR moves on the same edge
    assign x_next = (lfsr_q < (alpha ? C1 : C0)) ? PENALTY : REWARD;

    always_comb begin
        run_next = 8'd0;
        if (alpha == conv_action) begin
            run_next = (run_cnt >= CONV_MAX) ? CONV_MAX : run_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            x           <= REWARD;
            run_cnt     <= 8'd0;
            conv_action <= 1'b0;
            converged   <= 1'b0;
        end else if (en) begin
            x           <= x_next;
            run_cnt     <= run_next;
            conv_action <= alpha;
            converged   <= (run_next == CONV_MAX);
        end
    end

`ifdef TSETLIN_ENV_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            step_cnt <= 16'd0;
            pen_cnt  <= 16'd0;
        end else if (en) begin
            if (step_cnt != 16'hFFFF) begin
                step_cnt <= step_cnt + 16'd1;
            end
            if (x_next == PENALTY && pen_cnt != 16'hFFFF) begin
                pen_cnt <= pen_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tsetlin_env.sv
// tb/tb_tsetlin_env.sv - scoreboard bench for tsetlin_env (default and extreme-threshold instances)
module tb_tsetlin_env;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic en    = 1'b0;
    logic alpha = 1'b0;

    logic xa, ca, aa;
    logic xb, cb, ab;
`ifdef TSETLIN_ENV_STATS_EN
    logic [15:0] sa, pa, sb_cnt, pb;
`endif

    always #5 clk = ~clk;

    tsetlin_env dut_a (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .alpha       (alpha),
        .x           (xa),
        .converged   (ca),
        .conv_action (aa)
`ifdef TSETLIN_ENV_STATS_EN
        ,
        .step_cnt    (sa),
        .pen_cnt     (pa)
`endif
    );

    tsetlin_env #(
        .C0       (8'd0),
        .C1       (8'd255),
        .CONV_LEN (2)
    ) dut_b (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .alpha       (alpha),
        .x           (xb),
        .converged   (cb),
        .conv_action (ab)
`ifdef TSETLIN_ENV_STATS_EN
        ,
        .step_cnt    (sb_cnt),
        .pen_cnt     (pb)
`endif
    );

    typedef struct {
        logic       xa, ca, aa, xb, cb, ab;
        logic [7:0] lf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_lf;
    logic       m_xa, m_ca, m_aa, m_xb, m_cb, m_ab;
    int         m_ra, m_rb;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    task automatic model(input logic r, input logic e, input logic a);
        if (!r) begin
            m_lf = 8'hA5;
            {m_xa, m_ca, m_aa, m_xb, m_cb, m_ab} = '0;
            m_ra = 0;
            m_rb = 0;
        end else if (e) begin
            m_xa = (m_lf < (a ? 8'd204 : 8'd51));
            m_xb = (m_lf < (a ? 8'd255 : 8'd0));
            m_ra = (a == m_aa) ? ((m_ra + 1 > 16) ? 16 : m_ra + 1) : 0;
            m_rb = (a == m_ab) ? ((m_rb + 1 > 2) ? 2 : m_rb + 1) : 0;
            m_aa = a;
            m_ab = a;
            m_ca = (m_ra == 16);
            m_cb = (m_rb == 2);
            m_lf = ref_next(m_lf);
        end
    endtask

    // Drive one edge, push its expected outcome, return with post-edge state settled
    task automatic step(input logic r, input logic e, input logic a);
        exp_t t;
        @(negedge clk);
        rst   = r;
        en    = e;
        alpha = a;
        model(r, e, a);
        t.xa = m_xa; t.ca = m_ca; t.aa = m_aa;
        t.xb = m_xb; t.cb = m_cb; t.ab = m_ab;
        t.lf = m_lf;
        sb.push_back(t);
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("x_a",           16'(xa),               16'(mon_e.xa));
            chk("converged_a",   16'(ca),               16'(mon_e.ca));
            chk("conv_action_a", 16'(aa),               16'(mon_e.aa));
            chk("x_b",           16'(xb),               16'(mon_e.xb));
            chk("converged_b",   16'(cb),               16'(mon_e.cb));
            chk("conv_action_b", 16'(ab),               16'(mon_e.ab));
            chk("lfsr_a",        16'(dut_a.u_lfsr.q),   16'(mon_e.lf));
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    logic [7:0] seq_exp [4];
    logic [3:0] en_pat;
    int ones;

    initial begin
        seq_exp[0] = 8'hA5; seq_exp[1] = 8'h4A; seq_exp[2] = 8'h95; seq_exp[3] = 8'h2A;

        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        chk("reset_lfsr", 16'(dut_a.u_lfsr.q), 16'hA5);
        chk("reset_outs", {13'd0, xa, ca, aa}, 16'd0);
`ifdef TSETLIN_ENV_STATS_EN
        chk("reset_step_cnt", sa, 16'd0);
        chk("reset_pen_cnt",  pa, 16'd0);
`endif

        for (int i = 1; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0);
            chk("lfsr_seq", 16'(dut_a.u_lfsr.q), 16'(seq_exp[i]));
        end

        // conv_action is 0 here; the first alpha=1 sample clears the run
        for (int k = 1; k <= 17; k++) begin
            step(1'b1, 1'b1, 1'b1);
            if (k == 16) chk("conv_not_yet", 16'(ca), 16'd0);
            if (k == 17) chk("conv_reached", 16'(ca), 16'd1);
        end
        step(1'b1, 1'b1, 1'b0);
        chk("conv_drop", 16'(ca), 16'd0);

        en_pat = 4'b1011;
        for (int i = 0; i < 24; i++) begin
            step(1'b1, (i % 2) == 0, en_pat[i % 4]);
        end

        step(1'b0, 1'b1, 1'b1);
        chk("midrst_lfsr", 16'(dut_a.u_lfsr.q), 16'hA5);
        chk("midrst_outs", {10'd0, xa, ca, aa, xb, cb, ab}, 16'd0);
        for (int i = 1; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b1);
            chk("midrst_seq", 16'(dut_a.u_lfsr.q), 16'(seq_exp[i]));
        end

        step(1'b0, 1'b0, 1'b0);
        ones = 0;
        for (int i = 0; i < 255; i++) begin
            step(1'b1, 1'b1, 1'b0);
            ones += int'(xb);
        end
        chk("c0_zero_penalties", 16'(ones), 16'd0);
        ones = 0;
        for (int i = 0; i < 255; i++) begin
            step(1'b1, 1'b1, 1'b1);
            ones += int'(xb);
        end
        chk("c1_max_penalties", 16'(ones), 16'd254);

        for (int i = 0; i < 32; i++) begin
            step(1'b1, (i % 5) != 3, (i % 7) < 3);
        end

`ifdef TSETLIN_ENV_STATS_EN
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 70000; i++) begin
            step(1'b1, 1'b1, 1'b1);
        end
        chk("step_cnt_sat", sb_cnt, 16'hFFFF);
        chk("pen_cnt_sat",  pb,     16'hFFFF);
`endif

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #3;
        chk("scoreboard_drained", 16'(sb.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
